mem_arbiter: RTL

Two-master arbiter that shares the single-port word memory (combinational read, write on rising clk) between the multicycle CPU (master 0) and a loader/debug port (master 1). It uses a req/ack handshake, round-robin tie-breaking and a bounded lock for back-to-back bursts. It sits between the masters and the memory instance at top level; masters hold their request until they receive ack.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_hold_cnt.sv | 39 +++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arb_pkg                                                           |
// | Shared types and defaults for the two-master memory arbiter.         |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package mem_arb_pkg;

  // Arbiter FSM: idle, or serving master 0 / master 1 this cycle.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY0 = 2'd1,
    ARB_BUSY1 = 2'd2
  } arb_state_t;

  // Consecutive locked accesses allowed while the other master waits.
  localparam int LOCK_MAX_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/arb_hold_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arb_hold_cnt                                                          |
// | Saturating count of locked accesses taken while the other master     |
// | waits. at_max flags the last access before a forced release.         |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module arb_hold_cnt
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int            CW        = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] c_cnt_max = CW'(LOCK_MAX - 1);

  logic [CW-1:0] r_cnt;

  // Clear wins over increment; the count stops at LOCK_MAX-1 so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_max = (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_arbiter                                                           |
// | Req/ack arbiter sharing one single-port word memory between the CPU  |
// | (master 0) and a loader/debug port (master 1). Round-robin ties,     |
// | bounded lock for back-to-back bursts.                                 |
// | Revision: 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last_grant;
  logic       w_last_grant_nxt;
  logic       w_hold_clr;
  logic       w_hold_inc;
  logic       w_hold_at_max;

  arb_hold_cnt #(
    .LOCK_MAX (LOCK_MAX)
  ) u_hold_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_hold_clr),
    .inc     (w_hold_inc),
    .at_max  (w_hold_at_max)
  );

  // Grant selection, lock hold and forced release; the hold count restarts
  // from zero on every entry into a busy state because IDLE always clears it.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_hold_clr       = 1'b1;
    w_hold_inc       = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (m0_req && (!m1_req || r_last_grant)) begin
          w_state_nxt      = ARB_BUSY0;
          w_last_grant_nxt = 1'b0;
        end else if (m1_req) begin
          w_state_nxt      = ARB_BUSY1;
          w_last_grant_nxt = 1'b1;
        end
      end
      ARB_BUSY0: begin
        w_hold_clr = !m1_req;
        w_hold_inc = m1_req;
        if (!m0_lock || (m1_req && w_hold_at_max)) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_BUSY1: begin
        w_hold_clr = !m0_req;
        w_hold_inc = m0_req;
        if (!m1_lock || (m0_req && w_hold_at_max)) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State and round-robin pointer; last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Memory port mux decoded from state alone, so reset silences it at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    case (r_state)
      ARB_BUSY0: begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        m0_ack    = 1'b1;
      end
      ARB_BUSY1: begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        m1_ack    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Read data fans out to both masters; only the acked one samples it.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  // A granted master with lock set must still be presenting its access.
  a_lock_req0: assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == ARB_BUSY0 && m0_lock) |-> m0_req);
  a_lock_req1: assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == ARB_BUSY1 && m1_lock) |-> m1_req);
  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    !(m0_ack && m1_ack));

endmodule
`default_nettype wire
